// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN skips the iteration phase for trivial/special operands.
module muldiv_sequencer #(
   parameter int XLEN           = 32,
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [4:0]      rd_addr,
   input  logic            flush,
   output logic            busy,
   output logic            stall,
   output logic            result_valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      result_rd
);
   localparam int K  = XLEN / ITER_PER_CYCLE;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     a_q, b_q, m_q;
   logic [4:0]          rd_q;
   logic                sign_a, sign_b, dz_q, ovf_q;
   logic [2*XLEN-1:0]   acc, acc_nx;
   logic [CW-1:0]       cnt;
`ifdef MULDIV_EARLY_OUT_EN
   logic                zero_q;
   logic                early;
`endif

   // acc holds {hi, lo} for multiply and {remainder, quotient} for divide
   function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] x, input logic [XLEN-1:0] m);
      logic [XLEN:0] s;
      s = {1'b0, x[2*XLEN-1:XLEN]} + (x[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
      return {s, x[XLEN-1:1]};
   endfunction

   function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] x, input logic [XLEN-1:0] m);
      logic [XLEN:0] sh, tr;
      sh = x[2*XLEN-1:XLEN-1];
      tr = sh - {1'b0, m};
      if (!tr[XLEN]) return {tr[XLEN-1:0], x[XLEN-2:0], 1'b1};
      else           return {sh[XLEN-1:0], x[XLEN-2:0], 1'b0};
   endfunction

   logic                is_div, signed_a, signed_b, sa, sb, dz, ovf;
   logic [XLEN-1:0]     mag_a, mag_b, quo, rem, res_c;
   logic [2*XLEN-1:0]   prod;

   always_comb begin
      is_div   = op_q[2];
      signed_a = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
      signed_b = is_div ? ~op_q[0] : ~op_q[1];
      sa       = signed_a & a_q[XLEN-1];
      sb       = signed_b & b_q[XLEN-1];
      mag_a    = sa ? -a_q : a_q;
      mag_b    = sb ? -b_q : b_q;
      dz       = is_div & (b_q == '0);
      ovf      = is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
`ifdef MULDIV_EARLY_OUT_EN
      early    = dz | ovf | (a_q == '0) | (~is_div & (b_q == '0));
`endif
   end

   always_comb begin
      acc_nx = acc;
      for (int i = 0; i < ITER_PER_CYCLE; i++)
         acc_nx = is_div ? div_step(acc_nx, m_q) : mul_step(acc_nx, m_q);
   end

   always_comb begin
      prod = (sign_a ^ sign_b) ? -acc : acc;
      quo  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (is_div) begin
         if (op_q[1]) res_c = dz ? a_q : (ovf ? '0 : rem);
         else         res_c = dz ? '1  : (ovf ? a_q : quo);
      end else begin
         res_c = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
`ifdef MULDIV_EARLY_OUT_EN
      // a skipped multiply never built its product in acc
      if (zero_q) res_c = '0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         m_q          <= '0;
         rd_q         <= '0;
         sign_a       <= 1'b0;
         sign_b       <= 1'b0;
         dz_q         <= 1'b0;
         ovf_q        <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         result_valid <= 1'b0;
         result       <= '0;
         result_rd    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         zero_q       <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
         if (flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  op_q  <= op;
                  a_q   <= operand_a;
                  b_q   <= operand_b;
                  rd_q  <= rd_addr;
                  state <= S_PREP;
               end
               S_PREP: begin
                  sign_a <= sa;
                  sign_b <= sb;
                  m_q    <= is_div ? mag_b : mag_a;
                  acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                  cnt    <= CW'(K-1);
                  dz_q   <= dz;
                  ovf_q  <= ovf;
`ifdef MULDIV_EARLY_OUT_EN
                  zero_q <= ~is_div & ((a_q == '0) | (b_q == '0));
                  state  <= early ? S_FIXUP : S_ITER;
`else
                  state  <= S_ITER;
`endif
               end
               S_ITER: begin
                  acc <= acc_nx;
                  cnt <= cnt - 1'b1;
                  if (cnt == '0) state <= S_FIXUP;
               end
               S_FIXUP: begin
                  result       <= res_c;
                  result_rd    <= rd_q;
                  result_valid <= 1'b1;
                  state        <= S_DONE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy  = (state != S_IDLE);
   assign stall = ((state == S_IDLE) & start & ~flush) | (busy & (state != S_DONE));

   // special-case flags are latched alongside the signs; the mux reads the live ones
   logic unused_q;
   assign unused_q = dz_q ^ ovf_q;

endmodule
